// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit sequencer.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    localparam int DEFAULT_WORD_LENGTH  = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

endpackage

// File: rtl/tx_shift_reg.sv
// Loadable LSB-first right-shift register holding the payload of the frame in flight.
// Exposes the current LSB and the bit that becomes the LSB after the next shift.
module tx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_lsb,
    output logic             o_nextLsb
);

    logic [WIDTH-1:0] r_data;

    // Load wins over shift so a new frame always starts from a clean payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign o_lsb     = r_data[0];
    assign o_nextLsb = r_data[1];

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module uart_tx_sequencer
    import uart_tx_pkg::*;
#(
    parameter int WORD_LENGTH  = DEFAULT_WORD_LENGTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] data_in,
    output logic                   ready,
    output logic                   busy,
    output logic                   tx,
    output logic                   done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WORD_LENGTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_LENGTH - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [BAUD_W-1:0]  r_baudCnt;
    logic [BIT_W-1:0]   r_bitCnt;
    logic               r_tx;
    logic               w_nextTx;
    logic               w_load;
    logic               w_shift;
    logic               w_baudLast;
    logic               w_bitLast;
    logic               w_lsb;
    logic               w_nextLsb;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    tx_shift_reg #(
        .WIDTH(WORD_LENGTH)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_data   (data_in),
        .o_lsb    (w_lsb),
        .o_nextLsb(w_nextLsb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // tx is registered, so each branch selects the level of the bit that starts next cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextTx    = r_tx;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        done        = 1'b0;
        w_baudLast  = (r_baudCnt == BAUD_LAST);
        w_bitLast   = (r_bitCnt == BIT_LAST);
        case (r_state)
            IDLE: begin
                w_nextTx = IDLE_LEVEL;
                if (start) begin
                    w_nextState = START;
                    w_nextTx    = START_LEVEL;
                    w_load      = 1'b1;
                end
            end
            START: begin
                if (w_baudLast) begin
                    w_nextState = DATA;
                    w_nextTx    = w_lsb;
                end
            end
            DATA: begin
                if (w_baudLast) begin
                    w_shift = 1'b1;
                    if (w_bitLast) begin
`ifdef UART_TX_PARITY_EN
                        w_nextState = PARITY;
                        w_nextTx    = r_parity;
`else
                        w_nextState = STOP;
                        w_nextTx    = STOP_LEVEL;
`endif
                    end else begin
                        w_nextTx = w_nextLsb;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_baudLast) begin
                    w_nextState = STOP;
                    w_nextTx    = STOP_LEVEL;
                end
            end
`endif
            STOP: begin
                if (w_baudLast) begin
                    done        = 1'b1;
                    w_nextState = IDLE;
                    w_nextTx    = IDLE_LEVEL;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextTx    = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_tx      <= IDLE_LEVEL;
        end else begin
            r_tx <= w_nextTx;
            if (r_state == IDLE || w_baudLast) begin
                r_baudCnt <= '0;
            end else begin
                r_baudCnt <= r_baudCnt + 1'b1;
            end
            if (r_state != DATA) begin
                r_bitCnt <= '0;
            end else if (w_baudLast) begin
                r_bitCnt <= w_bitLast ? '0 : r_bitCnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the accepted payload since the shifter is empty by the parity bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^data_in;
        end
    end
`endif

    assign tx    = r_tx;
    assign ready = (r_state == IDLE);
    assign busy  = ~ready;

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 Parameter: WORD_LENGTH, 8, data bits per frame (≥2).
REQ-002 Parameter: CLKS_PER_BIT, 16, clk cycles per serial bit (≥2).
REQ-003 Port: clk  input  1  single clock; all state SHALL change on posedge clk only.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  frame request, sampled only when ready=1.
REQ-006 Port: data_in  input  WORD_LENGTH  frame payload, captured on acceptance.
REQ-007 Port: ready  output  1  high when idle and able to accept start.
REQ-008 Port: busy  output  1  high while a frame is in progress (busy = ~ready).
REQ-009 Port: tx  output  1  registered serial line, idle high.
REQ-010 Port: done  output  1  one-cycle pulse on the final stop-bit cycle.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-026.
REQ-012 Acceptance SHALL occur on the edge where state=IDLE and start=1; data_in loads into the shift sub-module (load=1) on that edge.
REQ-013 tx SHALL drive 0 (start bit) from the cycle after acceptance, for exactly CLKS_PER_BIT cycles.
REQ-014 DATA SHALL emit WORD_LENGTH bits LSB first, each held CLKS_PER_BIT cycles; the sub-module shifts right by one (shift=1) on the last cycle of each data bit.
REQ-015 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; width $clog2(CLKS_PER_BIT).
REQ-016 Bit counter SHALL count 0..WORD_LENGTH-1 in DATA; width $clog2(WORD_LENGTH); DATA->next state when bit counter=WORD_LENGTH-1 and baud counter wraps.
REQ-017 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; done=1 on its last cycle; state returns to IDLE on the following edge.
REQ-018 ready SHALL be 0 from the cycle after acceptance until the cycle after done; start while ready=0 SHALL be ignored, with no queuing.
REQ-019 start held high continuously SHALL launch back-to-back frames with exactly one idle-high cycle between the stop bit and the next start bit.
REQ-020 data_in changes after acceptance SHALL NOT affect the frame in progress.
REQ-021 Frame length SHALL be (WORD_LENGTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.

Reset
REQ-022 reset=1 SHALL force on the next edge: state=IDLE, tx=1, ready=1, busy=0, done=0, all counters=0, shift register=0.
REQ-023 reset asserted mid-frame SHALL abort the frame with no done pulse; tx=1 from the next edge.
REQ-024 reset takes priority over start on the same edge; no acceptance occurs.
REQ-025 The first acceptance SHALL be possible on the first edge after reset deasserts.

Configuration
REQ-026 With UART_TX_PARITY_EN defined, PARITY state SHALL follow DATA and emit the even-parity bit (XOR of captured payload) for CLKS_PER_BIT cycles before STOP.
REQ-027 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP; no parity logic or state encoding SHALL be synthesised.

Structure
REQ-028 Package uart_tx_pkg SHALL hold the state enum typedef, the default WORD_LENGTH and CLKS_PER_BIT constants, and the line-level constants IDLE_LEVEL=1, START_LEVEL=0 and STOP_LEVEL=1.
REQ-029 One sub-module, tx_shift_reg, SHALL implement the LSB-first loadable right-shift register (load priority over shift), driven by this block's load and shift strobes.

Verification (WORD_LENGTH=8, CLKS_PER_BIT=4)
REQ-030 start=1, data_in=0xA5 in IDLE -> tx=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done on cycle 40 after acceptance; ready=1 on cycle 41.
REQ-031 start pulsed at cycle 10 of a frame with data_in=0xFF -> ignored; the frame in progress is unchanged; no second frame follows.
REQ-032 start held high, data 0x01 then 0x80 -> two frames; exactly one tx=1 idle cycle between the stop bit and the next start bit.
REQ-033 reset=1 during data bit 3 -> tx=1 and ready=1 on the next edge; no done pulse; a new frame with 0x3C is accepted after reset deasserts.
REQ-034 UART_TX_PARITY_EN defined, data 0xA5 -> parity bit 0; data 0x01 -> parity bit 1; frame length 44 cycles.
REQ-035 reset and start asserted on the same edge -> no acceptance; tx stays 1.
